// File: rtl/rect_plotter.sv
// Rectangle pixel-write engine: walks a latched rectangle in raster order, one clipped VGA write per cycle.
// Optional macro RECT_PLOTTER_OUTLINE_EN adds req_outline to suppress interior pixels.
module rect_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int DIM_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [7:0]          req_x,
  input  logic [6:0]          req_y,
  input  logic [DIM_BITS-1:0] req_w,
  input  logic [DIM_BITS-1:0] req_h,
`ifdef RECT_PLOTTER_OUTLINE_EN
  input  logic                req_outline,
`endif
  input  logic [2:0]          req_colour,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [2:0]          colour,
  output logic                plot,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t              state, state_d;
  logic [DIM_BITS-1:0] col, col_d, row, row_d;
  logic [DIM_BITS-1:0] w_q, w_d, h_q, h_d;
  logic [7:0]          bx, bx_d;
  logic [6:0]          by, by_d;
  logic                outline_q, outline_d;
  logic [7:0]          x_d;
  logic [6:0]          y_d;
  logic [2:0]          colour_d;
  logic                plot_d, done_d;
  logic [8:0]          px;
  logic [7:0]          py;

  // Wide sums let off-screen pixels be detected rather than wrapped onto the far edge.
  function automatic logic pixel_on(input logic [8:0] sx, input logic [7:0] sy,
                                    input logic border, input logic outline);
    return (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H)) && (border || !outline);
  endfunction

  assign req_ready = (state == IDLE);

  always_comb begin
    state_d   = state;
    col_d     = col;
    row_d     = row;
    w_d       = w_q;
    h_d       = h_q;
    bx_d      = bx;
    by_d      = by;
    outline_d = outline_q;
    x_d       = x;
    y_d       = y;
    colour_d  = colour;
    plot_d    = 1'b0;
    done_d    = 1'b0;
    px        = 9'd0;
    py        = 8'd0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          state_d  = DRAW;
          col_d    = '0;
          row_d    = '0;
          w_d      = req_w;
          h_d      = req_h;
          bx_d     = req_x;
          by_d     = req_y;
          colour_d = req_colour;
`ifdef RECT_PLOTTER_OUTLINE_EN
          outline_d = req_outline;
`else
          outline_d = 1'b0;
`endif
        end
      end
      DRAW: begin
        if (col == w_q && row == h_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (col == w_q) begin
          col_d = '0;
          row_d = row + 1'b1;
        end else begin
          col_d = col + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so the pixel for the coming DRAW cycle is formed from next-state counters.
    if (state_d == DRAW) begin
      px     = {1'b0, bx_d} + 9'(col_d);
      py     = {1'b0, by_d} + 8'(row_d);
      x_d    = px[7:0];
      y_d    = py[6:0];
      plot_d = pixel_on(px, py,
                        (col_d == '0) || (col_d == w_d) || (row_d == '0) || (row_d == h_d),
                        outline_d);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      bx        <= '0;
      by        <= '0;
      outline_q <= 1'b0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      col       <= col_d;
      row       <= row_d;
      w_q       <= w_d;
      h_q       <= h_d;
      bx        <= bx_d;
      by        <= by_d;
      outline_q <= outline_d;
      x         <= x_d;
      y         <= y_d;
      colour    <= colour_d;
      plot      <= plot_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// Self-checking bench for rect_plotter: directed and random rectangles against a raster-loop model.
module tb_rect_plotter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_x = '0;
  logic [6:0] req_y = '0;
  logic [3:0] req_w = '0;
  logic [3:0] req_h = '0;
  logic [2:0] req_colour = '0;
`ifdef RECT_PLOTTER_OUTLINE_EN
  logic       req_outline = 1'b0;
`endif
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;

  int total = 0;
  int passed = 0;

  rect_plotter #(.SCREEN_W(160), .SCREEN_H(120), .DIM_BITS(4)) dut (
    .clock(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x(req_x),
    .req_y(req_y),
    .req_w(req_w),
    .req_h(req_h),
`ifdef RECT_PLOTTER_OUTLINE_EN
    .req_outline(req_outline),
`endif
    .req_colour(req_colour),
    .x(x),
    .y(y),
    .colour(colour),
    .plot(plot),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input int exp);
    total++;
    assert (obs === 16'(exp)) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive_req(input int ax, input int ay, input int aw, input int ah,
                           input int ac, input int ol);
    req_valid  = 1'b1;
    req_x      = 8'(ax);
    req_y      = 7'(ay);
    req_w      = 4'(aw);
    req_h      = 4'(ah);
    req_colour = 3'(ac);
`ifdef RECT_PLOTTER_OUTLINE_EN
    req_outline = ol[0];
`else
    if (ol != 0) $display("note: outline ignored in filled build");
`endif
  endtask

  task automatic scramble();
    req_x      = 8'($urandom);
    req_y      = 7'($urandom);
    req_w      = 4'($urandom);
    req_h      = 4'($urandom);
    req_colour = 3'($urandom);
  endtask

  // Called at the falling edge of the first DRAW cycle; returns at the falling edge of the IDLE cycle.
  task automatic check_draw(input int ax, input int ay, input int aw, input int ah,
                            input int ac, input int ol);
    for (int r = 0; r <= ah; r++) begin
      for (int c = 0; c <= aw; c++) begin
        int px;
        int py;
        bit border;
        bit ep;
        px = ax + c;
        py = ay + r;
        border = (c == 0) || (c == aw) || (r == 0) || (r == ah);
        ep = (px < 160) && (py < 120) && ((ol == 0) || border);
        chk("x", 16'(x), px % 256);
        chk("y", 16'(y), py % 128);
        chk("colour", 16'(colour), ac);
        chk("plot", 16'(plot), int'(ep));
        chk("done_in_draw", 16'(done), 0);
        chk("ready_in_draw", 16'(req_ready), 0);
        @(negedge clk);
      end
    end
    chk("done_pulse", 16'(done), 1);
    chk("plot_in_done", 16'(plot), 0);
    chk("ready_in_done", 16'(req_ready), 0);
    @(negedge clk);
    chk("ready_after_done", 16'(req_ready), 1);
    chk("done_after", 16'(done), 0);
    chk("plot_after", 16'(plot), 0);
  endtask

  task automatic run_req(input int ax, input int ay, input int aw, input int ah,
                         input int ac, input int ol);
    chk("ready_before", 16'(req_ready), 1);
    drive_req(ax, ay, aw, ah, ac, ol);
    @(negedge clk);
    req_valid = 1'b0;
    scramble();
    check_draw(ax, ay, aw, ah, ac, ol);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_plot", 16'(plot), 0);
    chk("rst_done", 16'(done), 0);
    chk("rst_ready", 16'(req_ready), 1);
    chk("rst_x", 16'(x), 0);
    chk("rst_y", 16'(y), 0);
    chk("rst_colour", 16'(colour), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_plot", 16'(plot), 0);

    run_req(20, 60, 3, 3, 3'b100, 0);
    run_req(158, 118, 3, 1, 3'b010, 0);
    run_req(5, 7, 0, 0, 3'b111, 0);
    run_req(200, 125, 15, 15, 3'b001, 0);
    run_req(150, 40, 15, 2, 3'b000, 0);

    // req_valid held high: second request is taken in the first IDLE cycle.
    drive_req(30, 30, 2, 1, 3'b011, 0);
    @(negedge clk);
    drive_req(90, 100, 1, 2, 3'b101, 0);
    check_draw(30, 30, 2, 1, 3'b011, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check_draw(90, 100, 1, 2, 3'b101, 0);

    // Reset during pixel 5 of a 4x4 request.
    drive_req(40, 50, 3, 3, 3'b110, 0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("pre_rst_plot", 16'(plot), 1);
      @(negedge clk);
    end
    chk("pix5_plot", 16'(plot), 1);
    chk("pix5_x", 16'(x), 40);
    chk("pix5_y", 16'(y), 51);
    reset = 1'b1;
    #1;
    chk("async_rst_plot", 16'(plot), 0);
    chk("async_rst_done", 16'(done), 0);
    chk("async_rst_ready", 16'(req_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk("no_done_after_rst", 16'(done), 0);
      chk("no_plot_after_rst", 16'(plot), 0);
      chk("ready_after_rst", 16'(req_ready), 1);
      @(negedge clk);
    end
    run_req(0, 0, 3, 3, 3'b100, 0);

`ifdef RECT_PLOTTER_OUTLINE_EN
    run_req(10, 10, 3, 3, 3'b010, 1);
    run_req(155, 116, 7, 5, 3'b001, 1);
`endif

    for (int n = 0; n < 24; n++) begin
      int ax;
      int ay;
      ax = (n % 3 == 0) ? int'($urandom_range(140, 255)) : int'($urandom_range(0, 255));
      ay = (n % 3 == 1) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 127));
`ifdef RECT_PLOTTER_OUTLINE_EN
      run_req(ax, ay, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
`else
      run_req(ax, ay, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 7)), 0);
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
